// File: rtl/sine_ctrl_pkg.sv
// Shared types and default widths for the sine sweep controller and its
// phase accumulator.
package sine_ctrl_pkg;

  localparam int ACC_W_DEFAULT   = 20;
  localparam int FCW_W_DEFAULT   = 16;
  localparam int DWELL_W_DEFAULT = 16;
  localparam int PHASE_W         = 10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/phase_accumulator.sv
// Modulo-2^ACC_W phase accumulator; the top PHASE_W bits are the sine
// generator phase, so a phase update is visible the cycle after enable.
module phase_accumulator
  import sine_ctrl_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEFAULT,
  parameter int INC_W = FCW_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  input  logic [INC_W-1:0]   incr,
  output logic [PHASE_W-1:0] phase
);

  logic [ACC_W-1:0] acc;

  // Clear has priority so an abort or restart never lets a tick through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc + ACC_W'(incr);
    end
  end

  assign phase = acc[ACC_W-1 -: PHASE_W];

endmodule

// File: rtl/sine_sweep_ctrl.sv
// Frequency sweep controller: steps the FCW from f_start toward f_stop,
// dwelling a programmable number of sample ticks on each value.
module sine_sweep_ctrl
  import sine_ctrl_pkg::*;
#(
  parameter int ACC_W   = ACC_W_DEFAULT,
  parameter int FCW_W   = FCW_W_DEFAULT,
  parameter int DWELL_W = DWELL_W_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick_en,
  input  logic               start,
  input  logic               abort,
  input  logic               mode,
  input  logic [FCW_W-1:0]   f_start,
  input  logic [FCW_W-1:0]   f_stop,
  input  logic [FCW_W-1:0]   f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic [FCW_W-1:0]   fcw,
  output logic               busy,
  output logic               done
);

  localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);

  sweep_state_t       state;
  logic [FCW_W-1:0]   f_start_r;
  logic [FCW_W-1:0]   f_stop_r;
  logic [FCW_W-1:0]   f_step_r;
  logic [DWELL_W-1:0] dwell_r;
  logic               mode_r;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_last;
  logic [FCW_W-1:0]   fcw_next;
  logic [FCW_W:0]     sum_up;
  logic [FCW_W:0]     diff_dn;
  logic               start_go;
  logic               acc_clear;
  logic               acc_en;

  assign start_go  = start && !abort && (state != ST_RUN);
  assign acc_clear = abort || start_go;
  assign acc_en    = tick_en && !abort && (state == ST_RUN);

  // A dwell of zero is treated as one tick per FCW.
  assign dwell_last = (dwell_r == '0) ? '0 : dwell_r - DWELL_ONE;

  // One extra bit catches overflow on the way up and underflow on the way down.
  always_comb begin
    sum_up   = {1'b0, fcw} + {1'b0, f_step_r};
    diff_dn  = {1'b0, fcw} - {1'b0, f_step_r};
    fcw_next = f_stop_r;
    if (f_start_r <= f_stop_r) begin
      if (sum_up <= {1'b0, f_stop_r}) fcw_next = sum_up[FCW_W-1:0];
    end else begin
      if (!diff_dn[FCW_W] && (diff_dn >= {1'b0, f_stop_r})) fcw_next = diff_dn[FCW_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      f_start_r   <= '0;
      f_stop_r    <= '0;
      f_step_r    <= '0;
      dwell_r     <= '0;
      mode_r      <= 1'b0;
      dwell_cnt   <= '0;
      fcw         <= '0;
      phase_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort) begin
      state       <= ST_IDLE;
      dwell_cnt   <= '0;
      fcw         <= '0;
      phase_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      phase_valid <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            f_start_r <= f_start;
            f_stop_r  <= f_stop;
            f_step_r  <= f_step;
            dwell_r   <= dwell;
            mode_r    <= mode;
            fcw       <= f_start;
            dwell_cnt <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
            state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (tick_en) begin
            phase_valid <= 1'b1;
            if (dwell_cnt == dwell_last) begin
              dwell_cnt <= '0;
              if (fcw == f_stop_r) begin
                if (mode_r) begin
                  fcw <= f_start_r;
                end else begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= ST_DONE;
                end
              end else begin
                fcw <= fcw_next;
              end
            end else begin
              dwell_cnt <= dwell_cnt + DWELL_ONE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  phase_accumulator #(
    .ACC_W(ACC_W),
    .INC_W(FCW_W)
  ) u_phase_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (acc_clear),
    .enable (acc_en),
    .incr   (fcw),
    .phase  (phase)
  );

endmodule

// File: tb/tb_sine_sweep_ctrl.sv
// Scoreboard bench for sine_sweep_ctrl: a sweep model built from the FCW
// stepping rules predicts phase/fcw/busy/done after every accepted tick.
module tb_sine_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        tick_en;
  logic        start;
  logic        abort;
  logic        mode;
  logic [15:0] f_start;
  logic [15:0] f_stop;
  logic [15:0] f_step;
  logic [15:0] dwell;
  logic [9:0]  phase;
  logic        phase_valid;
  logic [15:0] fcw;
  logic        busy;
  logic        done;

  typedef struct {
    int phase;
    int fcw;
    int busy;
    int done;
  } exp_t;

  exp_t exp_q[$];
  int   seq[$];
  int   checks = 0;
  int   errors = 0;
  int   m_acc  = 0;
  int   m_idx  = 0;
  int   m_fcw  = 0;
  int   m_busy = 0;
  int   m_done = 0;
  bit   m_run  = 0;
  bit   m_wrap = 0;

  sine_sweep_ctrl #(
    .ACC_W(20),
    .FCW_W(16),
    .DWELL_W(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_en     (tick_en),
    .start       (start),
    .abort       (abort),
    .mode        (mode),
    .f_start     (f_start),
    .f_stop      (f_stop),
    .f_step      (f_step),
    .dwell       (dwell),
    .phase       (phase),
    .phase_valid (phase_valid),
    .fcw         (fcw),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  // Monitor: every phase_valid pulse must match the oldest predicted tick.
  always @(negedge clk) begin
    if (rst_n && phase_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_phase_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("sb_phase", int'(phase), e.phase);
        checkOutput("sb_fcw", int'(fcw), e.fcw);
        checkOutput("sb_busy", int'(busy), e.busy);
        checkOutput("sb_done", int'(done), e.done);
      end
    end
  end

  task automatic applyStimulus(input logic st, input logic ab, input logic tk);
    start   = st;
    abort   = ab;
    tick_en = tk;
    @(posedge clk);
    #1;
    start   = 1'b0;
    abort   = 1'b0;
    tick_en = 1'b0;
  endtask

  // Per-tick FCW list for a sweep, derived directly from the stepping rules.
  task automatic buildSweep(input int fs, input int fe, input int st, input int dw, input bit md);
    int v;
    int d;
    seq.delete();
    d = (dw == 0) ? 1 : dw;
    v = fs;
    m_wrap = md;
    if (st == 0 && fs != fe) begin
      m_wrap = 1'b1;
      repeat (d) seq.push_back(fs);
    end else begin
      while (1) begin
        repeat (d) seq.push_back(v);
        if (v == fe) break;
        if (fs <= fe) v = (v + st > fe) ? fe : v + st;
        else          v = (v - st < fe) ? fe : v - st;
      end
    end
  endtask

  task automatic startSweep(input int fs, input int fe, input int st, input int dw,
                            input bit md, input bit with_tick);
    f_start = 16'(fs);
    f_stop  = 16'(fe);
    f_step  = 16'(st);
    dwell   = 16'(dw);
    mode    = md;
    buildSweep(fs, fe, st, dw, md);
    m_acc  = 0;
    m_idx  = 0;
    m_fcw  = fs;
    m_run  = 1'b1;
    m_busy = 1;
    m_done = 0;
    applyStimulus(1'b1, 1'b0, with_tick);
    f_start = 16'($urandom);
    f_stop  = 16'($urandom);
    f_step  = 16'($urandom);
    dwell   = 16'($urandom);
    mode    = 1'($urandom);
    checkOutput("start_fcw", int'(fcw), fs);
    checkOutput("start_busy", int'(busy), 1);
    checkOutput("start_done", int'(done), 0);
    checkOutput("start_phase", int'(phase), 0);
  endtask

  task automatic doTick();
    if (m_run) begin
      m_acc = (m_acc + seq[m_idx]) % (1 << 20);
      m_idx++;
      if (m_idx == seq.size()) begin
        if (m_wrap) begin
          m_idx = 0;
        end else begin
          m_run  = 1'b0;
          m_busy = 0;
          m_done = 1;
        end
      end
      m_fcw = m_run ? seq[m_idx] : seq[seq.size()-1];
      exp_q.push_back('{m_acc >> 10, m_fcw, m_busy, m_done});
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic abortSweep(input logic with_start, input logic with_tick);
    applyStimulus(with_start, 1'b1, with_tick);
    m_run = 1'b0; m_acc = 0; m_fcw = 0; m_busy = 0; m_done = 0;
    checkOutput("abort_phase", int'(phase), 0);
    checkOutput("abort_fcw", int'(fcw), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    checkOutput("abort_valid", int'(phase_valid), 0);
  endtask

  task automatic checkIdleOrDone();
    checkOutput("end_busy", int'(busy), m_busy);
    checkOutput("end_done", int'(done), m_done);
    checkOutput("end_fcw", int'(fcw), m_fcw);
    checkOutput("end_phase", int'(phase), m_acc >> 10);
  endtask

  initial begin
    int fs, fe, st, dw, n, diff;
    bit md;
    rst_n = 1'b0; tick_en = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    f_start = '0; f_stop = '0; f_step = '0; dwell = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_phase", int'(phase), 0);
    checkOutput("reset_fcw", int'(fcw), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_valid", int'(phase_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("idle_busy", int'(busy), 0);

    // Single tone, then a tick in DONE must leave phase untouched.
    startSweep(1024, 1024, 0, 4, 1'b0, 1'b0);
    repeat (4) doTick();
    checkIdleOrDone();
    doTick();
    checkOutput("done_hold_phase", int'(phase), 4);

    // Restart from DONE with a coincident tick; the tick must not accumulate.
    startSweep(100, 350, 100, 2, 1'b0, 1'b1);
    repeat (8) doTick();
    checkIdleOrDone();
    abortSweep(1'b0, 1'b0);

    startSweep(300, 100, 150, 1, 1'b1, 1'b0);
    repeat (12) doTick();
    checkOutput("cont_busy", int'(busy), 1);
    abortSweep(1'b0, 1'b0);

    startSweep(16'h8000, 16'h8000, 7, 1, 1'b1, 1'b0);
    repeat (32) doTick();
    checkOutput("wrap_phase", int'(phase), 0);
    f_start = 16'd5;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("run_start_ignored_fcw", int'(fcw), m_fcw);
    repeat (3) doTick();
    applyStimulus(1'b0, 1'b0, 1'b0);
    abortSweep(1'b1, 1'b1);

    startSweep(10, 20, 0, 2, 1'b0, 1'b0);
    repeat (7) doTick();
    checkOutput("step0_busy", int'(busy), 1);
    checkOutput("step0_fcw", int'(fcw), 10);
    abortSweep(1'b0, 1'b0);

    startSweep(65000, 65535, 60000, 1, 1'b0, 1'b0);
    repeat (2) doTick();
    checkIdleOrDone();
    startSweep(100, 0, 60000, 3, 1'b0, 1'b0);
    repeat (6) doTick();
    checkIdleOrDone();

    // Asynchronous reset in the middle of a sweep.
    startSweep(500, 3000, 700, 2, 1'b0, 1'b0);
    repeat (3) doTick();
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_phase", int'(phase), 0);
    checkOutput("arst_fcw", int'(fcw), 0);
    checkOutput("arst_busy", int'(busy), 0);
    checkOutput("arst_valid", int'(phase_valid), 0);
    m_run = 1'b0; m_acc = 0; m_fcw = 0; m_busy = 0; m_done = 0;
    exp_q.delete();
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("post_reset_busy", int'(busy), 0);
    startSweep(200, 500, 150, 1, 1'b0, 1'b0);
    repeat (3) doTick();
    checkIdleOrDone();

    // Randomized sweeps.
    for (int r = 0; r < 20; r++) begin
      fs = $urandom_range(0, 65535);
      fe = ($urandom_range(0, 4) == 0) ? fs : $urandom_range(0, 65535);
      diff = (fs > fe) ? fs - fe : fe - fs;
      st = (diff == 0) ? $urandom_range(0, 1000) : diff / $urandom_range(1, 6) + $urandom_range(1, 50);
      dw = $urandom_range(0, 3);
      md = 1'($urandom_range(0, 1));
      startSweep(fs, fe, st, dw, md, m_done ? 1'($urandom_range(0, 1)) : 1'b0);
      n = m_wrap ? seq.size() + $urandom_range(1, 10) : seq.size();
      repeat (n) doTick();
      checkIdleOrDone();
      if (!m_done || $urandom_range(0, 1) == 0) abortSweep(1'b0, 1'($urandom_range(0, 1)));
    end

    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sine_sweep_ctrl.md
SINE_SWEEP_CTRL -- requirements
Module: sine_sweep_ctrl

Interface
REQ-001 SHALL have parameter ACC_W, 20, phase accumulator width.
REQ-002 SHALL have parameter FCW_W, 16, frequency control word width.
REQ-003 SHALL have parameter DWELL_W, 16, dwell counter width.
REQ-004 SHALL have port clk  in  1  single system clock.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port tick_en  in  1  one-cycle 1 MHz sample strobe from the clock divider.
REQ-007 SHALL have port start  in  1  one-cycle sweep start request.
REQ-008 SHALL have port abort  in  1  one-cycle sweep abort request.
REQ-009 SHALL have port mode  in  1  0 = single sweep, 1 = continuous (restart at f_start).
REQ-010 SHALL have ports f_start, f_stop, f_step  in  FCW_W  sweep start FCW, stop FCW and step size (unsigned).
REQ-011 SHALL have port dwell  in  DWELL_W  ticks spent at each FCW.
REQ-012 SHALL have port phase  out  10  accumulator bits [ACC_W-1:ACC_W-10], feeding the sine generator phase input.
REQ-013 SHALL have ports phase_valid (out, 1, one-cycle pulse per phase update), fcw (out, FCW_W, current FCW), busy (out, 1) and done (out, 1).

Function
REQ-014 SHALL implement states IDLE, RUN and DONE.
REQ-015 SHALL latch f_start, f_stop, f_step, dwell and mode on start in IDLE or DONE; it SHALL load fcw=f_start, acc=0 and dwell_cnt=0, and enter RUN on the next cycle.
REQ-016 SHALL ignore start while in RUN; inputs other than start, abort and tick_en SHALL be sampled only at start.
REQ-017 In RUN, on each tick_en, SHALL set acc <= acc+fcw modulo 2^ACC_W and pulse phase_valid; phase SHALL change exactly one cycle after tick_en.
REQ-018 SHALL increment dwell_cnt on each RUN tick; on the tick where dwell_cnt == max(dwell,1)-1 it SHALL clear dwell_cnt and advance the FCW (dwell=0 behaves as 1).
REQ-019 SHALL advance the FCW as follows: if f_start <= f_stop, fcw <= min(fcw+f_step, f_stop); otherwise fcw <= max(fcw-f_step, f_stop); the computation SHALL use FCW_W+1 bits with no wrap.
REQ-020 SHALL treat reaching the end of a dwell period with fcw == f_stop as sweep end: in single mode it SHALL enter DONE; in continuous mode it SHALL reload fcw=f_start and stay in RUN (acc not cleared).
REQ-021 With f_step=0 and f_start != f_stop, SHALL hold fcw and remain in RUN until abort.
REQ-022 SHALL assert busy in RUN only; done SHALL be a level held in DONE until start or abort; phase SHALL hold in DONE.
REQ-023 abort SHALL force IDLE in the next cycle from any state, clearing acc, fcw, phase, busy and done; abort SHALL win over a simultaneous start or tick_en.
REQ-024 A start coinciding with tick_en in DONE SHALL start the sweep; that tick SHALL NOT advance acc.

Reset
REQ-025 rst_n low SHALL immediately force IDLE with acc, fcw, dwell_cnt, phase, phase_valid, busy and done all 0, including mid-sweep.
REQ-026 After rst_n deasserts, SHALL remain in IDLE until start.

Structure
REQ-027 SHALL take the state encoding and default widths ACC_W, FCW_W and DWELL_W from the shared package sine_ctrl_pkg.
REQ-028 SHALL place the accumulator in one sub-module, phase_accumulator (clear, enable, increment in, registered phase out); FSM, dwell counter and FCW stepping SHALL stay in the top.

Verification
REQ-029 Single tone: f_start=f_stop=1024, dwell=4, mode=0, 4 ticks -> phase 1,2,3,4, then done=1 and busy=0.
REQ-030 Up sweep: f_start=100, f_stop=350, f_step=100, dwell=2 -> fcw during ticks 100,100,200,200,300,300,350,350, then DONE.
REQ-031 Down sweep continuous: f_start=300, f_stop=100, f_step=150, dwell=1 -> fcw 300,150,100,300,150,... and busy stays 1.
REQ-032 Wrap: f_start=f_stop=0x8000, mode=1, 32 ticks -> phase steps by 32 each tick and returns to 0 on tick 32.
REQ-033 abort together with start and tick_en in RUN -> next cycle IDLE, phase=0, busy=0, no phase_valid.
REQ-034 rst_n pulsed low mid-RUN, between clock edges -> all outputs 0 before the next edge; start after release gives a normal sweep.
